// File: rtl/trig_tag_capture.sv
// Synchronises an asynchronous trigger, applies a dead time after each accepted
// rising edge and queues the PPS-relative cycle count of each edge in an FWFT FIFO.
module trig_tag_capture #(
  parameter int CNT_W       = 27,
  parameter int FIFO_DEPTH  = 4,
  parameter int DEAD_CYC    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          trig_in,
  input  logic                          pps_in,
  output logic [CNT_W-1:0]              tag_data,
  output logic                          tag_valid,
  input  logic                          tag_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic                          dead_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  typedef enum logic {IDLE, DEAD} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sd_q, sd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  state_t                 state_q, state_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [CNT_W-1:0]       mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0]       mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic                   trig_edge, push_req, do_push, do_pop, full;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], trig_in};
    sd_d      = sync_q[SYNC_STAGES-1];
    trig_edge = sync_q[SYNC_STAGES-1] & ~sd_q;
    // Saturate rather than wrap so a missing PPS never yields small, plausible tags
    if (pps_in)      cnt_d = '0;
    else if (&cnt_q) cnt_d = cnt_q;
    else             cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    push_req = 1'b0;
    case (state_q)
      IDLE: if (trig_edge) begin
        push_req = 1'b1;
        if (DEAD_CYC > 0) begin
          state_d = DEAD;
          dcnt_d  = DW'(DEAD_CYC - 1);
        end
      end
      DEAD: begin
        if (dcnt_q == '0) state_d = IDLE;
        else              dcnt_d  = dcnt_q - DW'(1);
      end
    endcase
  end

  assign tag_valid  = (level_q != '0);
  assign tag_data   = mem_q[rd_q];
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign dead_busy  = (state_q == DEAD);

  always_comb begin
    full    = (level_q == LW'(FIFO_DEPTH));
    do_pop  = tag_valid & tag_ready;
    // When full, a simultaneous pop frees the head slot, which is the write slot
    do_push = push_req & (~full | do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = cnt_q;
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
    level_d = level_q + LW'(do_push) - LW'(do_pop);
    ovf_d   = (push_req & full & ~do_pop) | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      sd_q    <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
      dcnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      sd_q    <= sd_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_trig_tag_capture.sv
// Bench for trig_tag_capture: table of dead-time cases plus directed sequences;
// expected tags are queued when the trigger is driven and compared on pop.
module tb_trig_tag_capture;
  localparam int SYNC = 2;

  logic        clk, rst_n, trig_in, pps_in, tag_ready, clr_ovf;
  logic [26:0] tag_data;
  logic        tag_valid, overflow, dead_busy;
  logic [2:0]  fifo_level;

  logic        trig2, pps2, ready2, clr2;
  logic [7:0]  tag_data2;
  logic        tag_valid2, overflow2, dead_busy2;
  logic [2:0]  fifo_level2;

  trig_tag_capture dut (
    .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .pps_in(pps_in),
    .tag_data(tag_data), .tag_valid(tag_valid), .tag_ready(tag_ready),
    .fifo_level(fifo_level), .overflow(overflow), .clr_ovf(clr_ovf),
    .dead_busy(dead_busy));

  trig_tag_capture #(.CNT_W(8), .FIFO_DEPTH(4), .DEAD_CYC(0), .SYNC_STAGES(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .trig_in(trig2), .pps_in(pps2),
    .tag_data(tag_data2), .tag_valid(tag_valid2), .tag_ready(ready2),
    .fifo_level(fifo_level2), .overflow(overflow2), .clr_ovf(clr2),
    .dead_busy(dead_busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference PPS-relative counter
  logic [26:0] mcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           mcnt <= '0;
    else if (pps_in)      mcnt <= '0;
    else if (mcnt != '1)  mcnt <= mcnt + 27'd1;
  end

  typedef struct { int gap; bit acc2; int busy; } vec_t;
  vec_t        vecs [4];
  logic [26:0] q [$];
  logic [26:0] exp_tag;
  int          n_chk, n_pass, busy_cnt;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One cycle: observe at the falling edge, return just after the rising edge
  task automatic tick();
    @(negedge clk);
    if (dead_busy) busy_cnt++;
    if (rst_n && tag_valid && tag_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_tag: got %0d, expected none", tag_data);
      end else begin
        exp_tag = q.pop_front();
        chk("tag_order", 64'(tag_data), 64'(exp_tag));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Two-cycle trigger pulse; returns in the cycle where the edge is seen internally
  task automatic rise(input bit keep);
    trig_in = 1'b1;
    if (keep) q.push_back(mcnt + 27'(SYNC));
    tick();
    tick();
    trig_in = 1'b0;
  endtask

  task automatic drain(input string name);
    tag_ready = 1'b1;
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    tick();
    tag_ready = 1'b0;
    chk(name, 64'(q.size()), 64'd0);
    chk({name, "_level"}, 64'(fifo_level), 64'd0);
  endtask

  initial begin
    vecs[0] = '{gap: 5,  acc2: 1'b0, busy: 8};
    vecs[1] = '{gap: 8,  acc2: 1'b0, busy: 8};
    vecs[2] = '{gap: 9,  acc2: 1'b1, busy: 16};
    vecs[3] = '{gap: 12, acc2: 1'b1, busy: 16};
    n_chk = 0; n_pass = 0; busy_cnt = 0;
    rst_n = 1'b0; trig_in = 1'b0; pps_in = 1'b0; tag_ready = 1'b0; clr_ovf = 1'b0;
    trig2 = 1'b0; pps2 = 1'b0; ready2 = 1'b1; clr2 = 1'b0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_tag_data",   64'(tag_data),   64'd0);
    chk("rst_tag_valid",  64'(tag_valid),  64'd0);
    chk("rst_fifo_level", 64'(fifo_level), 64'd0);
    chk("rst_overflow",   64'(overflow),   64'd0);
    chk("rst_dead_busy",  64'(dead_busy),  64'd0);
    ticks(2);
    rst_n = 1'b1;

    // Single held trigger at cycle ~100: one tag, latency SYNC+1
    ticks(97);
    trig_in = 1'b1;
    q.push_back(mcnt + 27'(SYNC));
    tick(); tick();
    chk("t1_valid_early", 64'(tag_valid), 64'd0);
    tick();
    chk("t1_valid",    64'(tag_valid),  64'd1);
    chk("t1_level",    64'(fifo_level), 64'd1);
    chk("t1_tag_data", 64'(tag_data),   64'(q[0]));
    ticks(20);
    chk("t1_one_tag", 64'(fifo_level), 64'd1);
    trig_in = 1'b0;
    drain("t1_drain");

    // Dead-time table
    tag_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      ticks(5);
      busy_cnt = 0;
      rise(1'b1);
      ticks(vecs[v].gap - 2);
      rise(vecs[v].acc2);
      ticks(30);
      chk("dead_busy_cycles", 64'(busy_cnt), 64'(vecs[v].busy));
      chk("dead_tags_drained", 64'(q.size()), 64'd0);
    end
    tag_ready = 1'b0;

    // Overflow: six edges, four kept
    for (int i = 0; i < 6; i++) begin
      rise(i < 4);
      ticks(18);
    end
    chk("t3_level",    64'(fifo_level), 64'd4);
    chk("t3_overflow", 64'(overflow),   64'd1);
    chk("t3_head",     64'(tag_data),   64'(q[0]));
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("t3_clr_ovf", 64'(overflow), 64'd0);

    // Drop in the same cycle as clr_ovf: overflow stays set
    rise(1'b0);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("drop_beats_clr", 64'(overflow), 64'd1);
    ticks(18);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("drop_clr_again", 64'(overflow), 64'd0);

    // Full FIFO: push and pop together
    rise(1'b1);
    tag_ready = 1'b1; tick(); tag_ready = 1'b0;
    chk("t4_level",    64'(fifo_level), 64'd4);
    chk("t4_overflow", 64'(overflow),   64'd0);
    chk("t4_head",     64'(tag_data),   64'(q[0]));
    ticks(18);
    drain("t4_drain");

    // PPS coincident with edge at cnt=1234
    pps_in = 1'b1; tick(); pps_in = 1'b0;
    for (int i = 0; i < 2000 && mcnt != 27'd1232; i++) tick();
    chk("t5_reach_1232", 64'(mcnt), 64'd1232);
    tag_ready = 1'b1;
    rise(1'b0);
    q.push_back(27'd1234);
    pps_in = 1'b1; tick(); pps_in = 1'b0;
    ticks(20);
    rise(1'b1);
    drain("t5_drain");

    // Saturation on the narrow-counter instance
    trig2 = 1'b1;
    tick(); tick(); tick();
    chk("sat_valid",     64'(tag_valid2),  64'd1);
    chk("sat_tag",       64'(tag_data2),   64'd255);
    chk("sat_dead_busy", 64'(dead_busy2),  64'd0);
    trig2 = 1'b0;
    ticks(3);
    chk("sat_drained", 64'(fifo_level2), 64'd0);

    // Reset with three queued tags and FSM in DEAD
    tag_ready = 1'b0;
    rise(1'b1); ticks(18);
    rise(1'b1); ticks(18);
    rise(1'b1); ticks(3);
    chk("t6_pre_level", 64'(fifo_level), 64'd3);
    chk("t6_pre_dead",  64'(dead_busy),  64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_tag_data",  64'(tag_data),   64'd0);
    chk("t6_tag_valid", 64'(tag_valid),  64'd0);
    chk("t6_level",     64'(fifo_level), 64'd0);
    chk("t6_overflow",  64'(overflow),   64'd0);
    chk("t6_dead_busy", 64'(dead_busy),  64'd0);
    q.delete();
    tick(); tick();
    rst_n = 1'b1;
    ticks(3);
    rise(1'b1);
    drain("t6_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
